// File: rtl/issue_queue_alu.sv
// ----------------------------------------------------------------------------
// issue_queue_alu
//
// Purpose:
//   Seven-entry issue queue for the ALU pipes. The queue accepts up to two new
//   entries per cycle from dispatch. It snoops four wakeup broadcast buses to
//   mark source operands ready. It retires entries when the select stage
//   grants them.
//
//   Entry format (21 bits):
//     [20]    dst write-enable
//     [19:15] src1 tag
//     [14]    src1 ready
//     [13]    reserved, always 0
//     [12:8]  src2 tag
//     [7]     src2 ready
//     [6:2]   dst tag
//     [1]     valid
//     [0]     issued, always 0
//
//   An empty slot always holds all zeros.
//
// Ports:
//   clk                        clock; all state updates on the rising edge
//   rst                        synchronous active-high reset
//   dispatch_din0/1            new entries; bit[1] requests allocation
//   wakeup_reg_ALU0/ALU1/LS/MD broadcast destination tags
//   wakeup_ALU_en0/en1/LS_en/MD_en
//                              broadcast valids
//   IQ_ALU_select_en           per-entry grant from the select stage
//   flush                      squash every entry
//   IQ_ALU_dout0..6            registered entry contents
//   dispatch_stall             fewer than two free entries
//   free_cnt                   number of invalid entries
// ----------------------------------------------------------------------------
module issue_queue_alu #(
    parameter int DEPTH = 7,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [20:0]      dispatch_din0,
    input  logic [20:0]      dispatch_din1,
    input  logic [TAG_W-1:0] wakeup_reg_ALU0,
    input  logic [TAG_W-1:0] wakeup_reg_ALU1,
    input  logic [TAG_W-1:0] wakeup_reg_LS,
    input  logic [TAG_W-1:0] wakeup_reg_MD,
    input  logic             wakeup_ALU_en0,
    input  logic             wakeup_ALU_en1,
    input  logic             wakeup_LS_en,
    input  logic             wakeup_MD_en,
    input  logic [DEPTH-1:0] IQ_ALU_select_en,
    input  logic             flush,
    output logic [20:0]      IQ_ALU_dout0,
    output logic [20:0]      IQ_ALU_dout1,
    output logic [20:0]      IQ_ALU_dout2,
    output logic [20:0]      IQ_ALU_dout3,
    output logic [20:0]      IQ_ALU_dout4,
    output logic [20:0]      IQ_ALU_dout5,
    output logic [20:0]      IQ_ALU_dout6,
    output logic             dispatch_stall,
    output logic [2:0]       free_cnt
);

    logic [DEPTH-1:0][20:0] entry_all;
    logic [DEPTH-1:0]       free_vec;
    logic [DEPTH-1:0]       lowest0;
    logic [DEPTH-1:0]       rest_vec;
    logic [DEPTH-1:0]       lowest1;
    logic [DEPTH-1:0]       alloc0_oh;
    logic [DEPTH-1:0]       alloc1_oh;
    logic [20:0]            din0_prep;
    logic [20:0]            din1_prep;
    logic                   din0_req;
    logic                   din1_req;

    // The reserved and issued bits of incoming entries carry no information.
    logic unused_din_bits;
    assign unused_din_bits = ^{dispatch_din0[13], dispatch_din0[0],
                               dispatch_din1[13], dispatch_din1[0]};

    // Tag zero is the hardwired zero register, so it is never broadcast.
    function automatic logic woken(input logic [TAG_W-1:0] tag);
        woken = (tag != '0) &&
                ((wakeup_ALU_en0 && (wakeup_reg_ALU0 == tag)) ||
                 (wakeup_ALU_en1 && (wakeup_reg_ALU1 == tag)) ||
                 (wakeup_LS_en   && (wakeup_reg_LS   == tag)) ||
                 (wakeup_MD_en   && (wakeup_reg_MD   == tag)));
    endfunction

    // Normalise a dispatched entry.
    // A source is ready on arrival when dispatch already marked it ready,
    // when it reads the zero register, or when its producer broadcasts
    // in the same cycle.
    function automatic logic [20:0] prep(input logic [20:0] din);
        prep = {din[20],
                din[19:15], din[14] | (din[19:15] == '0) | woken(din[19:15]),
                1'b0,
                din[12:8],  din[7]  | (din[12:8]  == '0) | woken(din[12:8]),
                din[6:2],
                1'b1, 1'b0};
    endfunction

    assign din0_prep = prep(dispatch_din0);
    assign din1_prep = prep(dispatch_din1);

    // Free slots are judged on current state only.
    // A slot granted this cycle becomes allocatable next cycle.
    always_comb begin
        free_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            free_cnt = free_cnt + 3'(free_vec[i]);
        end
    end

    assign dispatch_stall = (free_cnt < 3'd2);
    assign din0_req       = dispatch_din0[1] && !dispatch_stall;
    assign din1_req       = dispatch_din1[1] && !dispatch_stall;

    // x & -x isolates the lowest set bit.
    // Applying it a second time to the remainder finds the next free slot.
    assign lowest0   = free_vec & (~free_vec + DEPTH'(1));
    assign rest_vec  = free_vec & ~lowest0;
    assign lowest1   = rest_vec & (~rest_vec + DEPTH'(1));
    assign alloc0_oh = din0_req ? lowest0 : '0;
    assign alloc1_oh = din1_req ? (dispatch_din0[1] ? lowest1 : lowest0) : '0;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [20:0] entry_q;
            logic [20:0] entry_d;

            // Priority order: flush, then grant, then wakeup, then allocation.
            // Allocation only targets empty slots.
            always_comb begin
                entry_d = '0;
                if (flush) begin
                    entry_d = '0;
                end else if (entry_q[1]) begin
                    if (!IQ_ALU_select_en[gi]) begin
                        entry_d = entry_q;
                        if (woken(entry_q[19:15])) entry_d[14] = 1'b1;
                        if (woken(entry_q[12:8]))  entry_d[7]  = 1'b1;
                    end
                end else if (alloc0_oh[gi]) begin
                    entry_d = din0_prep;
                end else if (alloc1_oh[gi]) begin
                    entry_d = din1_prep;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    entry_q <= '0;
                end else begin
                    entry_q <= entry_d;
                end
            end

            assign free_vec[gi]  = ~entry_q[1];
            assign entry_all[gi] = entry_q;
        end
    endgenerate

    assign IQ_ALU_dout0 = entry_all[0];
    assign IQ_ALU_dout1 = entry_all[1];
    assign IQ_ALU_dout2 = entry_all[2];
    assign IQ_ALU_dout3 = entry_all[3];
    assign IQ_ALU_dout4 = entry_all[4];
    assign IQ_ALU_dout5 = entry_all[5];
    assign IQ_ALU_dout6 = entry_all[6];

endmodule

// File: tb/tb_issue_queue_alu.sv
// ----------------------------------------------------------------------------
// tb_issue_queue_alu
//
// Directed-vector bench for issue_queue_alu.
//
// Each stimulus step drives the inputs for one clock edge. After that edge it
// pushes the hand-computed queue state onto a scoreboard. A monitor on the
// falling edge pops each record and compares it against the DUT outputs.
// ----------------------------------------------------------------------------
module tb_issue_queue_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic [20:0] dispatch_din0, dispatch_din1;
    logic [4:0]  wakeup_reg_ALU0, wakeup_reg_ALU1, wakeup_reg_LS, wakeup_reg_MD;
    logic        wakeup_ALU_en0, wakeup_ALU_en1, wakeup_LS_en, wakeup_MD_en;
    logic [6:0]  IQ_ALU_select_en;
    logic        flush;
    logic [20:0] d0, d1, d2, d3, d4, d5, d6;
    logic        dispatch_stall;
    logic [2:0]  free_cnt;

    always #5 clk = ~clk;

    issue_queue_alu #(.DEPTH(7), .TAG_W(5)) dut (
        .clk              (clk),
        .rst              (rst),
        .dispatch_din0    (dispatch_din0),
        .dispatch_din1    (dispatch_din1),
        .wakeup_reg_ALU0  (wakeup_reg_ALU0),
        .wakeup_reg_ALU1  (wakeup_reg_ALU1),
        .wakeup_reg_LS    (wakeup_reg_LS),
        .wakeup_reg_MD    (wakeup_reg_MD),
        .wakeup_ALU_en0   (wakeup_ALU_en0),
        .wakeup_ALU_en1   (wakeup_ALU_en1),
        .wakeup_LS_en     (wakeup_LS_en),
        .wakeup_MD_en     (wakeup_MD_en),
        .IQ_ALU_select_en (IQ_ALU_select_en),
        .flush            (flush),
        .IQ_ALU_dout0     (d0),
        .IQ_ALU_dout1     (d1),
        .IQ_ALU_dout2     (d2),
        .IQ_ALU_dout3     (d3),
        .IQ_ALU_dout4     (d4),
        .IQ_ALU_dout5     (d5),
        .IQ_ALU_dout6     (d6),
        .dispatch_stall   (dispatch_stall),
        .free_cnt         (free_cnt)
    );

    typedef struct {
        logic [6:0][20:0] e;
        int               fc;
        logic             st;
        string            name;
    } exp_t;

    exp_t             sb[$];
    logic [6:0][20:0] exp_e;
    int               checks = 0;
    int               errors = 0;

    // Stored entry: valid=1, reserved=0, issued=0.
    function automatic logic [20:0] mk(input logic we, input logic [4:0] s1,
                                       input logic r1, input logic [4:0] s2,
                                       input logic r2, input logic [4:0] dst);
        mk = {we, s1, r1, 1'b0, s2, r2, dst, 1'b1, 1'b0};
    endfunction

    task automatic clear_inputs();
        rst = 1'b0; flush = 1'b0;
        dispatch_din0 = '0; dispatch_din1 = '0;
        wakeup_reg_ALU0 = '0; wakeup_reg_ALU1 = '0;
        wakeup_reg_LS = '0; wakeup_reg_MD = '0;
        wakeup_ALU_en0 = 1'b0; wakeup_ALU_en1 = 1'b0;
        wakeup_LS_en = 1'b0; wakeup_MD_en = 1'b0;
        IQ_ALU_select_en = '0;
    endtask

    // Apply the current inputs for one edge, queue the expected state, and
    // then return the inputs to idle.
    task automatic step(input string name, input int fc, input logic st);
        exp_t r;
        @(posedge clk);
        r.e = exp_e; r.fc = fc; r.st = st; r.name = name;
        sb.push_back(r);
        #1;
        clear_inputs();
    endtask

    // Monitor
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t r;
            logic [6:0][20:0] act;
            int bad;
            r   = sb.pop_front();
            act = {d6, d5, d4, d3, d2, d1, d0};
            bad = 0;
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (act[i] !== r.e[i]) begin
                    errors++; bad++;
                    $display("FAIL %s dout%0d: got %h expected %h", r.name, i, act[i], r.e[i]);
                end
            end
            checks++;
            if (free_cnt !== 3'(r.fc)) begin
                errors++; bad++;
                $display("FAIL %s free_cnt: got %0d expected %0d", r.name, free_cnt, r.fc);
            end
            checks++;
            if (dispatch_stall !== r.st) begin
                errors++; bad++;
                $display("FAIL %s dispatch_stall: got %b expected %b", r.name, dispatch_stall, r.st);
            end
            $display("txn %-14s free_cnt=%0d stall=%b mismatches=%0d", r.name, free_cnt, dispatch_stall, bad);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        exp_e = '0;

        // Reset with a dispatch request present: the request must be ignored.
        rst = 1'b1;
        dispatch_din0 = mk(1, 3, 0, 0, 0, 9);
        step("reset", 7, 0);

        // A src2 tag of 0 means the operand is ready on arrival.
        dispatch_din0 = mk(1, 3, 0, 0, 0, 9);
        exp_e[0] = mk(1, 3, 0, 0, 1, 9);
        step("alloc0", 6, 0);

        wakeup_ALU_en1 = 1; wakeup_reg_ALU1 = 5'd4;
        step("wake_miss", 6, 0);

        wakeup_ALU_en1 = 1; wakeup_reg_ALU1 = 5'd3;
        exp_e[0] = mk(1, 3, 1, 0, 1, 9);
        step("wake_hit", 6, 0);

        // Same-cycle MD wakeup of a dispatched source; din1 takes the next free slot.
        dispatch_din0 = mk(0, 7, 0, 8, 0, 10);
        dispatch_din1 = mk(1, 11, 1, 12, 0, 13);
        wakeup_MD_en = 1; wakeup_reg_MD = 5'd7;
        exp_e[1] = mk(0, 7, 1, 8, 0, 10);
        exp_e[2] = mk(1, 11, 1, 12, 0, 13);
        step("dual_disp", 4, 0);

        // din1 alone takes the lowest free slot; LS wakes entry 2's src2.
        dispatch_din1 = mk(1, 14, 0, 15, 0, 16);
        wakeup_LS_en = 1; wakeup_reg_LS = 5'd12;
        exp_e[2] = mk(1, 11, 1, 12, 1, 13);
        exp_e[3] = mk(1, 14, 0, 15, 0, 16);
        step("din1_only", 3, 0);

        dispatch_din0 = mk(1, 17, 0, 18, 0, 19);
        exp_e[4] = mk(1, 17, 0, 18, 0, 19);
        step("fill5", 2, 0);

        dispatch_din0 = mk(1, 20, 0, 21, 0, 22);
        dispatch_din1 = mk(1, 23, 0, 24, 0, 25);
        exp_e[5] = mk(1, 20, 0, 21, 0, 22);
        exp_e[6] = mk(1, 23, 0, 24, 0, 25);
        step("fill7", 0, 1);

        dispatch_din0 = mk(1, 1, 0, 1, 0, 1);
        dispatch_din1 = mk(1, 2, 0, 2, 0, 2);
        step("full_ignored", 0, 1);

        // Grant entries 0 and 2 while full; the dispatch is still stalled this cycle.
        IQ_ALU_select_en = 7'b0000101;
        dispatch_din0 = mk(1, 1, 0, 1, 0, 1);
        wakeup_ALU_en0 = 1; wakeup_reg_ALU0 = 5'd18;
        exp_e[0] = '0;
        exp_e[2] = '0;
        exp_e[4] = mk(1, 17, 0, 18, 1, 19);
        step("grant_0_2", 2, 0);

        dispatch_din0 = mk(0, 26, 0, 27, 0, 28);
        dispatch_din1 = mk(0, 29, 0, 30, 0, 31);
        exp_e[0] = mk(0, 26, 0, 27, 0, 28);
        exp_e[2] = mk(0, 29, 0, 30, 0, 31);
        step("refill_0_2", 0, 1);

        // Grant beats a same-cycle wakeup on the same entry.
        IQ_ALU_select_en = 7'b0001000;
        wakeup_LS_en = 1; wakeup_reg_LS = 5'd14;
        exp_e[3] = '0;
        step("grant_wake3", 1, 1);

        // Grant on an empty slot does nothing; a stalled dispatch is ignored.
        IQ_ALU_select_en = 7'b0001000;
        dispatch_din0 = mk(1, 5, 0, 6, 0, 7);
        step("grant_empty", 1, 1);

        // Flush overrides grant, wakeup and dispatch.
        flush = 1;
        IQ_ALU_select_en = 7'b0000001;
        dispatch_din0 = mk(1, 5, 0, 6, 0, 7);
        dispatch_din1 = mk(1, 8, 0, 9, 0, 10);
        wakeup_ALU_en0 = 1; wakeup_reg_ALU0 = 5'd21;
        exp_e = '0;
        step("flush", 7, 0);

        // A wakeup with tag 0 leaves the non-ready src1 alone.
        dispatch_din0 = mk(1, 1, 0, 2, 0, 3);
        wakeup_ALU_en0 = 1; wakeup_reg_ALU0 = 5'd0;
        exp_e[0] = mk(1, 1, 0, 2, 0, 3);
        step("post_flush", 6, 0);

        rst = 1;
        dispatch_din0 = mk(1, 4, 0, 5, 0, 6);
        wakeup_ALU_en0 = 1; wakeup_reg_ALU0 = 5'd1;
        exp_e = '0;
        step("rst_mid", 7, 0);

        step("idle", 7, 0);

        for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d records unchecked, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
